// File: rtl/timer_disp_pkg.sv
// Shared definitions for the timer BCD display slice.
//   - state_e      : conversion FSM states
//   - NUM_DIGITS   : number of multiplexed display digits
//   - BIN_W/BCD_W  : binary input width and BCD accumulator width
//   - SEG_*        : 7-segment patterns {g,f,e,d,c,b,a}, active-high
//   - add3_adjust  : double-dabble correction step on the BCD accumulator
package timer_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 3;
    localparam int BIN_W      = 8;
    localparam int BCD_W      = 12;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Any nibble >= 5 gets +3 so that the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (res[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder.
//   digit_i : BCD digit (values above 9 decode to all segments off)
//   blank_i : force all segments off
//   seg_o   : segments {g,f,e,d,c,b,a}, active-high
module bcd_to_seg7
    import timer_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            unique case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/timer_bcd_display.sv
// Converts the 8-bit timer count into three BCD digits with a sequential
// double-dabble engine and scans them onto a 3-digit 7-segment display.
//   clk        : system clock, rising edge
//   reset      : synchronous active-low reset
//   timer_time : binary count from the timer
//   bcd_hund/bcd_tens/bcd_ones : last completed conversion (registered)
//   bcd_valid  : one-cycle pulse when the bcd_* outputs update
//   busy       : conversion in progress
//   an         : one-hot digit select, bit0 = ones, bit2 = hundreds
//   seg        : segments {g,f,e,d,c,b,a} of the selected digit
//
// state | meaning
// IDLE  | waiting for timer_time to differ from the last converted value
// SHIFT | eight add-3/shift steps of the double-dabble conversion
// DONE  | publish the result, pulse bcd_valid, return to IDLE
module timer_bcd_display
    import timer_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 4,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      timer_time,
    output logic [3:0]            bcd_hund,
    output logic [3:0]            bcd_tens,
    output logic [3:0]            bcd_ones,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    localparam int             REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    state_e             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [BIN_W-1:0]   cap_q;
    logic [BIN_W-1:0]   last_q;
    logic [BCD_W-1:0]   acc_q;
    logic [2:0]         cnt_q;
    logic [3:0]         hund_q;
    logic [3:0]         tens_q;
    logic [3:0]         ones_q;
    logic               valid_q;
    logic               busy_q;

    logic [BCD_W+BIN_W-1:0] shift_d;

    logic [REF_W-1:0]   ref_q;
    logic [1:0]         idx_q;

    logic [3:0]         digit;
    logic               blank;

    // One double-dabble step: correct the BCD nibbles, then shift the
    // combined {bcd, bin} register left so the next binary MSB enters.
    assign shift_d = {add3_adjust(acc_q), bin_q} << 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            cap_q   <= '0;
            last_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Compare against the last converted value, so a change
                    // that arrived while busy is picked up here.
                    if (timer_time != last_q) begin
                        bin_q   <= timer_time;
                        cap_q   <= timer_time;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc_q, bin_q} <= shift_d;
                    cnt_q          <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    hund_q  <= acc_q[11:8];
                    tens_q  <= acc_q[7:4];
                    ones_q  <= acc_q[3:0];
                    last_q  <= cap_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd_hund  = hund_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign bcd_valid = valid_q;
    assign busy      = busy_q;

    // Display scan: each digit stays selected for REFRESH_DIV clocks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ref_q <= '0;
            idx_q <= 2'd0;
        end else if (ref_q == REF_LAST) begin
            ref_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            ref_q <= ref_q + REF_W'(1);
        end
    end

    assign an = NUM_DIGITS'(3'b001 << idx_q);

    // Leading-zero blanking: hundreds blank on zero, tens blank only when
    // hundreds is also zero; ones always shown.
    always_comb begin
        digit = ones_q;
        blank = 1'b0;
        unique case (idx_q)
            2'd1: begin
                digit = tens_q;
                blank = LZ_BLANK && (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                digit = hund_q;
                blank = LZ_BLANK && (hund_q == 4'd0);
            end
            default: begin
                digit = ones_q;
                blank = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_seg (
        .digit_i (digit),
        .blank_i (blank),
        .seg_o   (seg)
    );

endmodule
